// File: rtl/sample_interp_pkg.sv
// Shared audio definitions for the interpolator and the sigma-delta DAC.
// The defaults below set the sample width and the interpolation ratio.
package sample_interp_pkg;

    localparam int DW_DEF         = 16;
    localparam int RATIO_LOG2_DEF = 6;

    // Unsigned, offset-binary audio sample as consumed by the DAC.
    typedef logic [DW_DEF-1:0] sample_t;

endpackage

// File: rtl/sample_interp_if.sv
// Low-rate sample stream with a valid/ready handshake.
// The master sends samples and the slave (the interpolator) accepts them.
interface sample_interp_if
    import sample_interp_pkg::*;
#(
    parameter int DW = DW_DEF
);

    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;

    modport master (output s_data, output s_valid, input  s_ready);
    modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/sample_interp_slot.sv
// One-entry input buffer between the sample stream and the interpolator.
// A new sample is accepted only while the slot is empty; take empties it.
module sample_slot
    import sample_interp_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    sample_interp_if.slave s,
    input  logic          take,
    output logic [DW-1:0] nxt,
    output logic          nxt_valid,
    output logic          accept
);

    logic [DW-1:0] nxt_reg;
    logic          nxt_valid_reg;

    // Ready comes from state only, so it never depends on s_valid.
    assign s.s_ready = !nxt_valid_reg;
    assign accept    = s.s_valid && !nxt_valid_reg;
    assign nxt       = nxt_reg;
    assign nxt_valid = nxt_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nxt_reg       <= '0;
            nxt_valid_reg <= 1'b0;
        end else if (accept) begin
            nxt_reg       <= s.s_data;
            nxt_valid_reg <= 1'b1;
        end else if (take) begin
            nxt_valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/sample_interp.sv
// Linear interpolator feeding the sigma-delta DAC: one new output value per clk,
// ramping between consecutive input samples over 2^RATIO_LOG2 clks.
module sample_interp
    import sample_interp_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int RATIO_LOG2 = RATIO_LOG2_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    sample_interp_if.slave s,
    input  logic          clr_underrun,
    output logic [DW-1:0] dout,
    output logic          sample_tick,
    output logic          underrun
);

    localparam int PW = DW + RATIO_LOG2 + 2;
    localparam logic [RATIO_LOG2-1:0] PHASE_LAST = '1;

    logic [RATIO_LOG2-1:0] phase_reg, phase_next;
    logic [DW-1:0]         prev_reg, prev_next;
    logic [DW-1:0]         cur_reg, cur_next;
    logic [DW-1:0]         dout_reg, dout_next;
    logic                  tick_reg, tick_next;
    logic                  underrun_reg, underrun_next;
    logic                  started_reg, started_next;

    logic [DW-1:0]   nxt;
    logic            nxt_valid;
    logic            accept;
    logic            wrap;
    logic signed [PW-1:0] prev_ext, cur_ext, phase_ext, diff, prod;

    assign wrap = (phase_reg == PHASE_LAST);

    sample_slot #(.DW(DW)) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (s),
        .take      (wrap),
        .nxt       (nxt),
        .nxt_valid (nxt_valid),
        .accept    (accept)
    );

    // Operands are widened so the signed product cannot overflow; the
    // arithmetic shift then gives floor division for falling segments.
    assign prev_ext  = $signed({{(PW-DW){1'b0}}, prev_reg});
    assign cur_ext   = $signed({{(PW-DW){1'b0}}, cur_reg});
    assign phase_ext = $signed({{(PW-RATIO_LOG2){1'b0}}, phase_reg});
    assign diff      = cur_ext - prev_ext;
    assign prod      = diff * phase_ext;

    always_comb begin
        phase_next    = phase_reg + RATIO_LOG2'(1);
        prev_next     = prev_reg;
        cur_next      = cur_reg;
        tick_next     = 1'b0;
        underrun_next = underrun_reg;
        started_next  = started_reg | accept;
        // Result always lies between prev and cur, so truncation is lossless.
        dout_next     = DW'(prev_ext + (prod >>> RATIO_LOG2));

        if (clr_underrun) begin
            underrun_next = 1'b0;
        end

        if (wrap) begin
            tick_next = 1'b1;
            prev_next = cur_reg;
            if (nxt_valid) begin
                cur_next = nxt;
            end else if (started_reg) begin
                underrun_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg    <= '0;
            prev_reg     <= '0;
            cur_reg      <= '0;
            dout_reg     <= '0;
            tick_reg     <= 1'b0;
            underrun_reg <= 1'b0;
            started_reg  <= 1'b0;
        end else begin
            phase_reg    <= phase_next;
            prev_reg     <= prev_next;
            cur_reg      <= cur_next;
            dout_reg     <= dout_next;
            tick_reg     <= tick_next;
            underrun_reg <= underrun_next;
            started_reg  <= started_next;
        end
    end

    assign dout        = dout_reg;
    assign sample_tick = tick_reg;
    assign underrun    = underrun_reg;

endmodule

// File: tb/tb_sample_interp.sv
// Bench for sample_interp with R = 4: expected dout values for each segment
// are queued when its samples are sent and popped as the DUT produces them.
module tb_sample_interp;

    localparam int DW = 16;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr_underrun = 1'b0;
    logic [DW-1:0] dout;
    logic          sample_tick;
    logic          underrun;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] exp_q[$];

    sample_interp_if #(.DW(DW)) sif ();

    sample_interp #(.DW(DW), .RATIO_LOG2(RL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s            (sif.slave),
        .clr_underrun (clr_underrun),
        .dout         (dout),
        .sample_tick  (sample_tick),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic push4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic [DW-1:0] d);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
        exp_q.push_back(d);
    endtask

    // Returns at the negedge right after a wrap edge.
    task automatic sync_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (sample_tick) seen = 1'b1;
        end
        if (!seen) check_eq("sync_timeout", 32'd0, 32'd1);
    endtask

    // Called at a negedge; the sample is accepted at the following posedge.
    task automatic send(input logic [DW-1:0] d);
        int guard = 0;
        sif.s_data  = d;
        sif.s_valid = 1'b1;
        while (!sif.s_ready && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 16) check_eq("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        sif.s_valid = 1'b0;
        $display("[TB] sent sample %h", d);
    endtask

    // Compares one full period (phase 0..3) against the queued expectations.
    task automatic period(input string tag);
        logic [DW-1:0] e;
        logic [DW-1:0] got[4];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got[i] = dout;
            if (exp_q.size() == 0) begin
                check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq($sformatf("%s_dout%0d", tag, i), 32'(dout), 32'(e));
            end
            check_eq($sformatf("%s_tick%0d", tag, i), 32'(sample_tick), 32'(i == 3));
        end
        $display("[TB] %s: dout %h %h %h %h underrun %0b", tag, got[0], got[1], got[2], got[3], underrun);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int since;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_tick", 32'(sample_tick), 32'd0);
        check_eq("rst_underrun", 32'(underrun), 32'd0);
        check_eq("rst_ready", 32'(sif.s_ready), 32'd1);
        rst_n = 1'b1;

        // Idle: no samples, outputs stay quiet, tick every 4 clks.
        since = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("idle_dout", 32'(dout), 32'd0);
            check_eq("idle_underrun", 32'(underrun), 32'd0);
            check_eq("idle_ready", 32'(sif.s_ready), 32'd1);
            if (since >= 0) begin
                since++;
                check_eq("idle_tick", 32'(sample_tick), 32'(since == 4));
                if (sample_tick) since = 0;
            end else if (sample_tick) begin
                since = 0;
            end
        end
        check_eq("idle_tick_seen", 32'(since >= 0), 32'd1);
        $display("[TB] idle phase done");

        sync_tick();
        send(16'h1000);
        sync_tick();

        push4(16'h0000, 16'h0400, 16'h0800, 16'h0C00); send(16'h2000); period("ramp_0_1000");
        push4(16'h1000, 16'h1400, 16'h1800, 16'h1C00); send(16'h0000); period("ramp_1000_2000");
        push4(16'h2000, 16'h1800, 16'h1000, 16'h0800); send(16'hFFFF); period("fall_2000_0");
        push4(16'h0000, 16'h3FFF, 16'h7FFF, 16'hBFFF); send(16'h0000); period("rise_0_ffff");
        push4(16'hFFFF, 16'hBFFF, 16'h7FFF, 16'h3FFF); send(16'h0003); period("fall_ffff_0");
        push4(16'h0000, 16'h0000, 16'h0001, 16'h0002); send(16'h0000); period("round_0_3");
        push4(16'h0003, 16'h0002, 16'h0001, 16'h0000); send(16'h1234); period("round_3_0");
        check_eq("no_underrun_yet", 32'(underrun), 32'd0);

        // Starve: nothing sent, the wrap ending this period underruns.
        push4(16'h0000, 16'h048D, 16'h091A, 16'h0DA7); period("ramp_0_1234");
        check_eq("starve_underrun", 32'(underrun), 32'd1);
        push4(16'h1234, 16'h1234, 16'h1234, 16'h1234); period("hold_1234");
        check_eq("underrun_sticky", 32'(underrun), 32'd1);

        // Clear, then offer a sample exactly on the wrap edge.
        clr_underrun = 1'b1;
        @(posedge clk); #1;
        clr_underrun = 1'b0;
        @(negedge clk);
        check_eq("clr_underrun", 32'(underrun), 32'd0);
        check_eq("clr_hold_dout", 32'(dout), 32'h1234);
        @(negedge clk);
        @(negedge clk);
        sif.s_data  = 16'h4000;
        sif.s_valid = 1'b1;
        @(posedge clk); #1;
        sif.s_valid = 1'b0;
        $display("[TB] sent sample 4000 on wrap edge");
        @(negedge clk);
        check_eq("wrapsend_tick", 32'(sample_tick), 32'd1);
        check_eq("wrapsend_underrun", 32'(underrun), 32'd1);
        check_eq("wrapsend_ready", 32'(sif.s_ready), 32'd0);
        push4(16'h1234, 16'h1234, 16'h1234, 16'h1234); period("hold_after_wrapsend");
        push4(16'h1234, 16'h1DA7, 16'h291A, 16'h348D); period("ramp_1234_4000");

        // Clear and set on the same edge: the set wins.
        clr_underrun = 1'b1;
        @(posedge clk); #1;
        clr_underrun = 1'b0;
        @(negedge clk);
        check_eq("clr2_underrun", 32'(underrun), 32'd0);
        @(negedge clk);
        @(negedge clk);
        clr_underrun = 1'b1;
        @(posedge clk); #1;
        clr_underrun = 1'b0;
        @(negedge clk);
        check_eq("setwins_tick", 32'(sample_tick), 32'd1);
        check_eq("setwins_underrun", 32'(underrun), 32'd1);
        $display("[TB] clear/set collision checked");

        // Reset mid-segment with a buffered sample.
        send(16'h7777);
        @(negedge clk);
        check_eq("pre_rst_ready", 32'(sif.s_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_dout", 32'(dout), 32'd0);
        check_eq("midrst_tick", 32'(sample_tick), 32'd0);
        check_eq("midrst_underrun", 32'(underrun), 32'd0);
        check_eq("midrst_ready", 32'(sif.s_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_eq("postrst_dout", 32'(dout), 32'd0);
            check_eq("postrst_underrun", 32'(underrun), 32'd0);
            check_eq("postrst_ready", 32'(sif.s_ready), 32'd1);
        end
        $display("[TB] post-reset idle done");
        check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
